// File: rtl/comp_n_seq.sv
// rtl/comp_n_seq.sv - serial NPTS-point signed min/max tracker with tagged offsets from the minimum
// Collects points, then walks them through one shared subtractor before presenting the result.
module comp_n_seq #(
   parameter int WIDTH = 32,
   parameter int NPTS  = 3,
   parameter int IDXW  = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    type_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        minp,
   output logic [WIDTH-1:0]        maxp,
   output logic [IDXW-1:0]         min_idx,
   output logic [IDXW-1:0]         max_idx,
   output logic [NPTS*WIDTH-1:0]   diff_flat
);

   localparam logic [1:0]      ST_COLLECT = 2'd0;
   localparam logic [1:0]      ST_DIFF    = 2'd1;
   localparam logic [1:0]      ST_OUT     = 2'd2;
   localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NPTS - 1);

   logic [1:0]             r_state;
   logic [IDXW-1:0]        r_count;
   logic [IDXW-1:0]        r_k;
   logic [WIDTH-1:0]       r_pts [NPTS];
   logic                   r_type;
   logic [WIDTH-1:0]       r_minp;
   logic [WIDTH-1:0]       r_maxp;
   logic [IDXW-1:0]        r_min_idx;
   logic [IDXW-1:0]        r_max_idx;
   logic [NPTS*WIDTH-1:0]  r_diff;
   logic                   r_out_valid;

   logic                   w_accept;
   logic [WIDTH-1:0]       w_pk;
   logic [WIDTH-2:0]       w_d;
   logic [WIDTH-1:0]       w_diff_k;

   assign in_ready  = (r_state == ST_COLLECT);
   assign w_accept  = in_valid && (r_state == ST_COLLECT);
   assign out_valid = r_out_valid;
   assign minp      = r_minp;
   assign maxp      = r_maxp;
   assign min_idx   = r_min_idx;
   assign max_idx   = r_max_idx;
   assign diff_flat = r_diff;

   always_comb begin
      w_pk = '0;
      for (int i = 0; i < NPTS; i++) begin
         if (r_k == IDXW'(i)) w_pk = r_pts[i];
      end
   end

   // The MSB of the difference is overwritten by the tag, so only the low bits are subtracted.
   assign w_d      = w_pk[WIDTH-2:0] - r_minp[WIDTH-2:0];
   assign w_diff_k = (r_k == r_min_idx) ? '0 : {r_type, w_d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_COLLECT;
         r_count     <= '0;
         r_k         <= '0;
         for (int i = 0; i < NPTS; i++) r_pts[i] <= '0;
         r_type      <= 1'b0;
         r_minp      <= '0;
         r_maxp      <= '0;
         r_min_idx   <= '0;
         r_max_idx   <= '0;
         r_diff      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_accept) begin
                  for (int i = 0; i < NPTS; i++) begin
                     if (r_count == IDXW'(i)) r_pts[i] <= in_data;
                  end
                  if (r_count == '0) begin
                     r_minp    <= in_data;
                     r_maxp    <= in_data;
                     r_min_idx <= '0;
                     r_max_idx <= '0;
                     r_type    <= type_in;
                  end else begin
                     // Strict compares so ties keep the earliest index.
                     if ($signed(in_data) < $signed(r_minp)) begin
                        r_minp    <= in_data;
                        r_min_idx <= r_count;
                     end
                     if ($signed(in_data) > $signed(r_maxp)) begin
                        r_maxp    <= in_data;
                        r_max_idx <= r_count;
                     end
                  end
                  if (r_count == LAST_IDX) begin
                     r_count <= '0;
                     r_k     <= '0;
                     r_state <= ST_DIFF;
                  end else begin
                     r_count <= r_count + IDXW'(1);
                  end
               end
            end
            ST_DIFF: begin
               for (int i = 0; i < NPTS; i++) begin
                  if (r_k == IDXW'(i)) r_diff[i*WIDTH +: WIDTH] <= w_diff_k;
               end
               if (r_k == LAST_IDX) begin
                  r_state     <= ST_OUT;
                  r_out_valid <= 1'b1;
               end else begin
                  r_k <= r_k + IDXW'(1);
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_COLLECT;
               end
            end
            default: r_state <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_comp_n_seq.sv
// tb/tb_comp_n_seq.sv - directed bench for comp_n_seq (NPTS=3/WIDTH=32 and NPTS=4/WIDTH=16)
module tb_comp_n_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        type_in, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, minp, maxp;
   logic [2:0]  min_idx, max_idx;
   logic [95:0] diff_flat;

   logic        b_type_in, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [15:0] b_in_data, b_minp, b_maxp;
   logic [1:0]  b_min_idx, b_max_idx;
   logic [63:0] b_diff_flat;

   int total = 0;
   int bad   = 0;

   comp_n_seq #(.WIDTH(32), .NPTS(3), .IDXW(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .type_in(type_in), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .minp(minp), .maxp(maxp), .min_idx(min_idx),
      .max_idx(max_idx), .diff_flat(diff_flat)
   );

   comp_n_seq #(.WIDTH(16), .NPTS(4), .IDXW(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .type_in(b_type_in), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .minp(b_minp), .maxp(b_maxp), .min_idx(b_min_idx),
      .max_idx(b_max_idx), .diff_flat(b_diff_flat)
   );

   task automatic send_pt(input logic [31:0] d, input logic t);
      int b;
      b = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; type_in = t;
      while (!in_ready && b < 200) begin @(negedge clk); b++; end
      total++;
      if (b >= 200) begin bad++; $display("FAIL send_timeout in_ready=%b exp=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_pt4(input logic [15:0] d, input logic t);
      int b;
      b = 0;
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = d; b_type_in = t;
      while (!b_in_ready && b < 200) begin @(negedge clk); b++; end
      total++;
      if (b >= 200) begin bad++; $display("FAIL send4_timeout in_ready=%b exp=1", b_in_ready); end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask

   // Returns the number of rising edges (sampled 1 time unit after) until out_valid rises.
   task automatic wait_out(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid && n < 200);
      total++;
      if (!out_valid) begin bad++; $display("FAIL wait_out_timeout out_valid=%b exp=1", out_valid); end
   endtask

   task automatic consume();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL consume_out_valid got=%b exp=0", out_valid); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL consume_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      type_in = 0; in_valid = 0; in_data = '0; out_ready = 0;
      b_type_in = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
      #12;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if ({minp, maxp} !== 64'h0) begin bad++; $display("FAIL reset_minmax got=%h exp=0", {minp, maxp}); end
      total++; if ({min_idx, max_idx} !== 6'h0) begin bad++; $display("FAIL reset_idx got=%h exp=0", {min_idx, max_idx}); end
      total++; if (diff_flat !== 96'h0) begin bad++; $display("FAIL reset_diff got=%h exp=0", diff_flat); end
      total++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_b_hs got=%b%b exp=10", b_in_ready, b_out_valid); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int n;
      send_pt(32'd5, 1'b1); send_pt(32'hFFFFFFFD, 1'b0); send_pt(32'd10, 1'b0);
      wait_out(n);
      total++; if (n != 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", n); end
      total++; if (minp !== 32'hFFFFFFFD) begin bad++; $display("FAIL basic_minp got=%h exp=fffffffd", minp); end
      total++; if (maxp !== 32'h0000000A) begin bad++; $display("FAIL basic_maxp got=%h exp=0000000a", maxp); end
      total++; if (min_idx !== 3'd1 || max_idx !== 3'd2) begin bad++; $display("FAIL basic_idx got=%0d/%0d exp=1/2", min_idx, max_idx); end
      total++;
      if (diff_flat !== {32'h8000000D, 32'h0, 32'h80000008}) begin
         bad++; $display("FAIL basic_diff got=%h exp=8000000d0000000080000008", diff_flat);
      end
      consume();
   endtask

   task automatic test_ties();
      int n;
      send_pt(32'd7, 1'b0); send_pt(32'd7, 1'b1); send_pt(32'd7, 1'b1);
      wait_out(n);
      total++; if (minp !== 32'd7 || maxp !== 32'd7) begin bad++; $display("FAIL ties_minmax got=%h/%h exp=7/7", minp, maxp); end
      total++; if (min_idx !== 3'd0 || max_idx !== 3'd0) begin bad++; $display("FAIL ties_idx got=%0d/%0d exp=0/0", min_idx, max_idx); end
      total++; if (diff_flat !== 96'h0) begin bad++; $display("FAIL ties_diff got=%h exp=0", diff_flat); end
      consume();
   endtask

   task automatic test_backpressure();
      int n;
      send_pt(32'd5, 1'b1); send_pt(32'hFFFFFFFD, 1'b0); send_pt(32'd10, 1'b0);
      wait_out(n);
      @(negedge clk); in_valid = 1'b1; in_data = 32'd100; type_in = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hs cyc=%0d got=%b%b exp=10", c, out_valid, in_ready);
         end
         total++;
         if (minp !== 32'hFFFFFFFD || diff_flat !== {32'h8000000D, 32'h0, 32'h80000008}) begin
            bad++; $display("FAIL bp_stable cyc=%0d minp=%h diff=%h", c, minp, diff_flat);
         end
      end
      consume();
      @(posedge clk); #1; in_valid = 1'b0;
      send_pt(32'd50, 1'b1); send_pt(32'd200, 1'b1);
      wait_out(n);
      total++; if (minp !== 32'd50 || min_idx !== 3'd1) begin bad++; $display("FAIL bp_min got=%h@%0d exp=32@1", minp, min_idx); end
      total++; if (maxp !== 32'd200 || max_idx !== 3'd2) begin bad++; $display("FAIL bp_max got=%h@%0d exp=c8@2", maxp, max_idx); end
      total++;
      if (diff_flat !== {32'd150, 32'd0, 32'd50}) begin
         bad++; $display("FAIL bp_diff got=%h exp=000000960000000000000032", diff_flat);
      end
      consume();
   endtask

   task automatic test_bubbles();
      int n;
      logic        v [6];
      logic [31:0] d [6];
      v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      d = '{32'd5, 32'd999, 32'd999, 32'hFFFFFFFD, 32'd999, 32'd10};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); in_valid = v[i]; in_data = d[i]; type_in = (i == 0);
      end
      @(negedge clk); in_valid = 1'b0;
      wait_out(n);
      total++; if (minp !== 32'hFFFFFFFD || maxp !== 32'd10) begin bad++; $display("FAIL bub_minmax got=%h/%h exp=fffffffd/a", minp, maxp); end
      total++; if (min_idx !== 3'd1 || max_idx !== 3'd2) begin bad++; $display("FAIL bub_idx got=%0d/%0d exp=1/2", min_idx, max_idx); end
      total++;
      if (diff_flat !== {32'h8000000D, 32'h0, 32'h80000008}) begin
         bad++; $display("FAIL bub_diff got=%h exp=8000000d0000000080000008", diff_flat);
      end
      consume();
   endtask

   task automatic test_reset_mid_diff();
      int n;
      send_pt(32'd5, 1'b1); send_pt(32'hFFFFFFFD, 1'b0); send_pt(32'd10, 1'b0);
      @(posedge clk); #1; rst_n = 1'b0; #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_hs got=%b%b exp=01", out_valid, in_ready); end
      total++; if ({minp, maxp} !== 64'h0) begin bad++; $display("FAIL rst_minmax got=%h exp=0", {minp, maxp}); end
      total++; if ({min_idx, max_idx} !== 6'h0) begin bad++; $display("FAIL rst_idx got=%h exp=0", {min_idx, max_idx}); end
      total++; if (diff_flat !== 96'h0) begin bad++; $display("FAIL rst_diff got=%h exp=0", diff_flat); end
      @(negedge clk); rst_n = 1'b1;
      send_pt(32'd1, 1'b1); send_pt(32'd2, 1'b0); send_pt(32'd3, 1'b0);
      wait_out(n);
      total++; if (minp !== 32'd1 || maxp !== 32'd3) begin bad++; $display("FAIL rst_next_minmax got=%h/%h exp=1/3", minp, maxp); end
      total++;
      if (diff_flat !== {32'h80000002, 32'h80000001, 32'h0}) begin
         bad++; $display("FAIL rst_next_diff got=%h exp=800000028000000100000000", diff_flat);
      end
      consume();
   endtask

   task automatic test_npts4();
      int n;
      send_pt4(16'h7FFF, 1'b0); send_pt4(16'h8000, 1'b1);
      send_pt4(16'h0000, 1'b1); send_pt4(16'h0001, 1'b1);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!b_out_valid && n < 200);
      total++; if (n != 4) begin bad++; $display("FAIL n4_latency got=%0d exp=4", n); end
      total++; if (b_minp !== 16'h8000 || b_min_idx !== 2'd1) begin bad++; $display("FAIL n4_min got=%h@%0d exp=8000@1", b_minp, b_min_idx); end
      total++; if (b_maxp !== 16'h7FFF || b_max_idx !== 2'd0) begin bad++; $display("FAIL n4_max got=%h@%0d exp=7fff@0", b_maxp, b_max_idx); end
      total++;
      if (b_diff_flat !== {16'h0001, 16'h0000, 16'h0000, 16'h7FFF}) begin
         bad++; $display("FAIL n4_diff got=%h exp=0001000000007fff", b_diff_flat);
      end
      @(negedge clk); b_out_ready = 1'b1;
      @(posedge clk); #1; b_out_ready = 1'b0;
      total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin bad++; $display("FAIL n4_consume got=%b%b exp=01", b_out_valid, b_in_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_backpressure();
      test_bubbles();
      test_reset_mid_diff();
      test_npts4();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/comp_n_seq.md
Name: comp_n_seq

Overview:
- Parametrised sequential successor to the three-point min/max comparator used in primitive setup.
- Accepts NPTS signed vertex coordinates serially, one per handshake.
- Tracks the running min and max, then computes each point's offset from the min using one shared subtractor over NPTS cycles.
- Presents min, max, their indices and the tagged offsets on a valid/ready output for the rasteriser's edge setup.

Parameters:
- WIDTH, 32, coordinate width in bits; signed two's complement; minimum 4.
- NPTS, 3, points per primitive; legal range 2..8.
- IDXW, 3, index width; must satisfy 2^IDXW >= NPTS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- type_in  input  1  primitive type tag; sampled with point 0.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a point.
- in_data  input  WIDTH  signed coordinate.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- minp  output  WIDTH  minimum coordinate.
- maxp  output  WIDTH  maximum coordinate.
- min_idx  output  IDXW  index of the minimum.
- max_idx  output  IDXW  index of the maximum.
- diff_flat  output  NPTS*WIDTH  tagged offset of point k at [k*WIDTH +: WIDTH].

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state: COLLECT, count=0. minp, maxp, min_idx, max_idx, diff_flat, out_valid, the point array and the type register are all 0.
- in_ready = (state==COLLECT), combinational. It reads 1 during and immediately after reset.
- COLLECT: on in_valid&&in_ready:
  - pts[count] <= in_data.
  - If count==0: minp=maxp=in_data, min_idx=max_idx=0, type register <= type_in.
  - Else signed compare: strictly less replaces min, strictly greater replaces max. Ties keep the lowest index.
  - count increments. On the accept at count==NPTS-1: count<=0, k<=0, state<=DIFF.
  - Cycles without a handshake change nothing.
- DIFF: one point per cycle, k = 0..NPTS-1.
  - d = pts[k] - minp, modulo 2^WIDTH.
  - If k==min_idx: diff[k] <= 0, with no tag.
  - Otherwise: diff[k] <= {type, d[WIDTH-2:0]}. Tag bit replaces the MSB; overflow beyond WIDTH-1 bits is discarded.
  - After k==NPTS-1: state<=OUT, out_valid<=1.
- Latency: last input accepted at edge E0 -> out_valid high after edge E0+NPTS. Throughput is one primitive per 2*NPTS+1 cycles minimum.
- OUT:
  - All outputs are registered and held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: out_valid<=0, state<=COLLECT. in_ready is 1 the following cycle.
  - Result outputs keep their values until overwritten by the next primitive.
- No input is accepted in DIFF or OUT; in_valid there is ignored, and the source must hold it.
- Reset mid-operation (any state): immediate return to reset values. The partial primitive is discarded and no output handshake occurs.
- Equal points other than min_idx produce {type, 0}.

Test Plan:
- NPTS=3, WIDTH=32, type=1, points 5, -3, 10:
  - minp=0xFFFFFFFD, maxp=0x0000000A, min_idx=1, max_idx=2.
  - diff0=0x80000008, diff1=0, diff2=0x8000000D.
  - out_valid rises 3 cycles after the last accept.
- Ties, type=0, points 7, 7, 7:
  - minp=maxp=7, min_idx=max_idx=0.
  - diffs 0, 0, 0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and a new point pending.
  - Outputs stable, in_ready=0, nothing accepted.
  - out_ready=1 -> handshake; next cycle in_ready=1 and the pending point is accepted as index 0.
- Input bubbles: in_valid toggling 1,0,0,1,0,1.
  - Exactly 3 points captured in order; result matches scenario 1.
- Reset mid-DIFF: pulse rst_n low for 1 cycle.
  - All outputs read 0 asynchronously.
  - The next primitive 1, 2, 3 gives minp=1, maxp=3, diffs 0, {type,1}, {type,2}.
- NPTS=4, WIDTH=16, type=0, points 0x7FFF, 0x8000, 0x0000, 0x0001:
  - minp=0x8000, min_idx=1, maxp=0x7FFF, max_idx=0.
  - diff0=0x7FFF (overflow truncated, MSB=type=0), diff2=0x0000 (0-0x8000 wraps to 0x8000, truncated then tagged), diff3=0x0001.
